// File: rtl/transaction_control.sv
// Ledger transfer sequencer: loads the 48-bit ledger word, applies one checked
// transfer between 16-bit accounts and hands the image back for write-back.
module transaction_control #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  sender,
  input  logic [1:0]  receiver,
  input  logic [15:0] amount,
  input  logic        finished_init,
  input  logic        mem_done,
  input  logic        load_registers,
  input  logic [47:0] mem_data,
  output logic        load_memory,
  output logic [2:0]  process,
  output logic [47:0] datapath_out,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_ok,
  output logic [2:0]  error_code
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_LOAD, S_COMPUTE, S_WB_WAIT, S_WB_DONE
  } state_t;

  state_t        state_q;
  logic [1:0]    sender_q, receiver_q;
  logic [15:0]   amount_q;
  logic [47:0]   image_q, image_d;
  logic [CW-1:0] cnt_q;
  logic          seen_low_q;
  logic          load_memory_q, busy_q, tx_done_q, tx_ok_q;
  logic [2:0]    process_q, error_q, err_d;
  logic [15:0]   bal_s, bal_r;
  logic [16:0]   sum_r;
  logic          stall, expire;

  assign load_memory  = load_memory_q;
  assign process      = process_q;
  assign datapath_out = image_q;
  assign busy         = busy_q;
  assign tx_done      = tx_done_q;
  assign tx_ok        = tx_ok_q;
  assign error_code   = error_q;

  always_comb begin
    bal_s = '0;
    bal_r = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sender_q == 2'(i))   bal_s = image_q[i*16 +: 16];
      if (receiver_q == 2'(i)) bal_r = image_q[i*16 +: 16];
    end
    sum_r   = {1'b0, bal_r} + {1'b0, amount_q};
    err_d   = 3'b000;
    image_d = image_q;
    if (sender_q == 2'd3 || receiver_q == 2'd3) err_d = 3'b001;
    else if (sender_q == receiver_q)            err_d = 3'b010;
    else if (bal_s < amount_q)                  err_d = 3'b011;
    else if (sum_r[16])                         err_d = 3'b100;
    else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sender_q == 2'(i))   image_d[i*16 +: 16] = bal_s - amount_q;
        if (receiver_q == 2'(i)) image_d[i*16 +: 16] = sum_r[15:0];
      end
    end
  end

  // A cycle spent waiting in a handshake state without progress.
  always_comb begin
    stall  = (state_q == S_REQ_LOAD && !load_registers) ||
             (state_q == S_WB_WAIT  &&  mem_done) ||
             (state_q == S_WB_DONE  && !(seen_low_q && mem_done));
    expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      sender_q      <= '0;
      receiver_q    <= '0;
      amount_q      <= '0;
      image_q       <= '0;
      cnt_q         <= '0;
      seen_low_q    <= 1'b0;
      load_memory_q <= 1'b0;
      process_q     <= '0;
      busy_q        <= 1'b0;
      tx_done_q     <= 1'b0;
      tx_ok_q       <= 1'b0;
      error_q       <= '0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && finished_init && mem_done) begin
            sender_q      <= sender;
            receiver_q    <= receiver;
            amount_q      <= amount;
            busy_q        <= 1'b1;
            load_memory_q <= 1'b1;
            process_q     <= 3'b001;
            error_q       <= '0;
            tx_ok_q       <= 1'b0;
            cnt_q         <= '0;
            seen_low_q    <= 1'b0;
            state_q       <= S_REQ_LOAD;
          end
        end
        S_REQ_LOAD: begin
          if (load_registers) begin
            image_q       <= mem_data;
            load_memory_q <= 1'b0;
            process_q     <= 3'b011;
            cnt_q         <= '0;
            state_q       <= S_COMPUTE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_COMPUTE: begin
          image_q   <= image_d;
          error_q   <= err_d;
          process_q <= 3'b100;
          cnt_q     <= '0;
          state_q   <= S_WB_WAIT;
        end
        S_WB_WAIT: begin
          if (!mem_done) begin
            seen_low_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_WB_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WB_DONE: begin
          if (seen_low_q && mem_done) begin
            tx_done_q <= 1'b1;
            tx_ok_q   <= (error_q == 3'b000);
            busy_q    <= 1'b0;
            process_q <= 3'b000;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Timeout overrides whatever the wait state scheduled above.
      if (stall && expire) begin
        error_q       <= 3'b111;
        tx_ok_q       <= 1'b0;
        tx_done_q     <= 1'b1;
        busy_q        <= 1'b0;
        load_memory_q <= 1'b0;
        process_q     <= 3'b000;
        cnt_q         <= '0;
        state_q       <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_transaction_control.sv
// Self-checking bench for transaction_control: directed cases from the test
// plan plus randomized transfers checked against an arithmetic ledger model.
module tb_transaction_control;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  sender = '0;
  logic [1:0]  receiver = '0;
  logic [15:0] amount = '0;
  logic        finished_init = 1'b0;
  logic        mem_done = 1'b1;
  logic        load_registers = 1'b0;
  logic [47:0] mem_data = '0;
  logic        load_memory;
  logic [2:0]  process;
  logic [47:0] datapath_out;
  logic        busy, tx_done, tx_ok;
  logic [2:0]  error_code;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  transaction_control #(.TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .resetn(resetn), .start(start), .sender(sender),
    .receiver(receiver), .amount(amount), .finished_init(finished_init),
    .mem_done(mem_done), .load_registers(load_registers), .mem_data(mem_data),
    .load_memory(load_memory), .process(process), .datapath_out(datapath_out),
    .busy(busy), .tx_done(tx_done), .tx_ok(tx_ok), .error_code(error_code)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ledger rules expressed on plain integer balances.
  function automatic void model(input logic [47:0] w, input logic [1:0] s, input logic [1:0] r,
                                input logic [15:0] a, output logic [2:0] e, output logic [47:0] nw);
    int unsigned bal[3];
    for (int i = 0; i < 3; i++) bal[i] = int'(w[16*i +: 16]);
    if (s == 2'd3 || r == 2'd3)      e = 3'd1;
    else if (s == r)                 e = 3'd2;
    else if (bal[s] < int'(a))       e = 3'd3;
    else if (bal[r] + a > 65535)     e = 3'd4;
    else begin
      bal[s] = bal[s] - a;
      bal[r] = bal[r] + a;
      e = 3'd0;
    end
    nw = {16'(bal[2]), 16'(bal[1]), 16'(bal[0])};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".load_memory"}, 64'(load_memory), 64'd0);
    check({tag, ".process"}, 64'(process), 64'd0);
    check({tag, ".datapath_out"}, 64'(datapath_out), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".tx_done"}, 64'(tx_done), 64'd0);
    check({tag, ".tx_ok"}, 64'(tx_ok), 64'd0);
    check({tag, ".error_code"}, 64'(error_code), 64'd0);
  endtask

  // Full transfer with a cooperative memory; ld/hold/low are wait lengths.
  task automatic run_tx(input string tag, input logic [1:0] s, input logic [1:0] r,
                        input logic [15:0] a, input logic [47:0] w,
                        input int unsigned ld, input int unsigned hold, input int unsigned low);
    logic [2:0]  e;
    logic [47:0] nw;
    model(w, s, r, a, e, nw);
    finished_init = 1'b1; mem_done = 1'b1;
    start = 1'b1; sender = s; receiver = r; amount = a;
    tick();
    start = 1'b0;
    check({tag, ".accept_process"}, 64'(process), 64'd1);
    check({tag, ".accept_load"}, 64'(load_memory), 64'd1);
    check({tag, ".accept_busy"}, 64'(busy), 64'd1);
    check({tag, ".accept_err"}, 64'(error_code), 64'd0);
    sender = 2'($urandom); receiver = 2'($urandom); amount = 16'($urandom);
    for (int i = 0; i < int'(ld); i++) begin
      start = 1'b1;
      tick();
      check({tag, ".busy_start_ignored"}, 64'(process), 64'd1);
    end
    start = 1'b0;
    load_registers = 1'b1; mem_data = w;
    tick();
    load_registers = 1'b0; mem_data = {16'($urandom), 16'($urandom), 16'($urandom)};
    check({tag, ".compute_process"}, 64'(process), 64'd3);
    check({tag, ".captured"}, 64'(datapath_out), 64'(w));
    check({tag, ".load_dropped"}, 64'(load_memory), 64'd0);
    tick();
    check({tag, ".wb_process"}, 64'(process), 64'd4);
    check({tag, ".wb_image"}, 64'(datapath_out), 64'(nw));
    check({tag, ".wb_err"}, 64'(error_code), 64'(e));
    for (int i = 0; i < int'(hold); i++) tick();
    mem_done = 1'b0;
    for (int i = 0; i <= int'(low); i++) begin
      tick();
      check({tag, ".wbdone_process"}, 64'(process), 64'd4);
      check({tag, ".wbdone_no_pulse"}, 64'(tx_done), 64'd0);
    end
    mem_done = 1'b1;
    tick();
    check({tag, ".tx_done"}, 64'(tx_done), 64'd1);
    check({tag, ".tx_ok"}, 64'(tx_ok), 64'(e == 3'd0));
    check({tag, ".busy_end"}, 64'(busy), 64'd0);
    check({tag, ".process_end"}, 64'(process), 64'd0);
    check({tag, ".final_err"}, 64'(error_code), 64'(e));
    tick();
    check({tag, ".pulse_single"}, 64'(tx_done), 64'd0);
    check({tag, ".idle_hold"}, 64'(datapath_out), 64'(nw));
  endtask

  initial begin
    logic [47:0] w, held;
    logic [15:0] a;

    // Reset
    resetn = 1'b0;
    tick(); tick();
    check_idle_zero("reset");
    resetn = 1'b1;
    tick();

    // Directed transfers
    run_tx("basic", 2'd0, 2'd2, 16'd100, {16'd500, 16'd0, 16'd300}, 0, 0, 0);
    check("basic.result", 64'(datapath_out), 64'({16'd600, 16'd0, 16'd200}));
    run_tx("insufficient", 2'd1, 2'd0, 16'd51, {16'd7, 16'd50, 16'd9}, 2, 1, 2);
    run_tx("same_idx", 2'd2, 2'd2, 16'd1, {16'd3, 16'd4, 16'd5}, 1, 0, 0);
    run_tx("bad_idx", 2'd3, 2'd0, 16'd1, {16'd3, 16'd4, 16'd5}, 0, 2, 0);
    run_tx("overflow", 2'd1, 2'd2, 16'h0020, {16'hFFF0, 16'd1000, 16'd5}, 0, 0, 1);
    run_tx("zero_amt", 2'd0, 2'd1, 16'd0, {16'd1, 16'd2, 16'd3}, 0, 0, 0);
    run_tx("exact_fit", 2'd0, 2'd1, 16'h000F, {16'd0, 16'hFFF0, 16'h000F}, 0, 0, 0);

    // Load timeout
    held = datapath_out;
    finished_init = 1'b1; mem_done = 1'b1;
    start = 1'b1; sender = 2'd0; receiver = 2'd1; amount = 16'd1;
    tick();
    start = 1'b0;
    check("tmo.accept", 64'(process), 64'd1);
    for (int i = 0; i < 63; i++) tick();
    check("tmo.not_yet", 64'(tx_done), 64'd0);
    tick();
    check("tmo.tx_done", 64'(tx_done), 64'd1);
    check("tmo.err", 64'(error_code), 64'd7);
    check("tmo.load", 64'(load_memory), 64'd0);
    check("tmo.busy", 64'(busy), 64'd0);
    check("tmo.process", 64'(process), 64'd0);
    check("tmo.tx_ok", 64'(tx_ok), 64'd0);
    check("tmo.image", 64'(datapath_out), 64'(held));
    tick();
    check("tmo.single", 64'(tx_done), 64'd0);

    // Start dropped while memory not ready
    finished_init = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("noinit.busy", 64'(busy), 64'd0);
    check("noinit.process", 64'(process), 64'd0);
    check("noinit.err_held", 64'(error_code), 64'd7);
    finished_init = 1'b1; mem_done = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; mem_done = 1'b1;
    check("memnotidle.busy", 64'(busy), 64'd0);
    tick();
    check("noinit.no_pulse", 64'(tx_done), 64'd0);

    // Reset during write-back wait
    start = 1'b1; sender = 2'd0; receiver = 2'd1; amount = 16'd5;
    tick();
    start = 1'b0;
    load_registers = 1'b1; mem_data = {16'd1, 16'd2, 16'd30};
    tick();
    load_registers = 1'b0;
    tick();
    check("rst_wb.in_wb", 64'(process), 64'd4);
    resetn = 1'b0;
    tick();
    check_idle_zero("rst_wb");
    resetn = 1'b1;
    tick();
    check("rst_wb.no_pulse", 64'(tx_done), 64'd0);
    run_tx("after_rst", 2'd2, 2'd0, 16'd10, {16'd40, 16'd0, 16'd0}, 0, 0, 0);

    // Randomized transfers
    for (int n = 0; n < 24; n++) begin
      w = '0;
      for (int k = 0; k < 3; k++) begin
        a = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(65000, 65535)) : 16'($urandom_range(0, 2000));
        w[16*k +: 16] = a;
      end
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1500));
      run_tx("rand", 2'($urandom), 2'($urandom), a, w,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/transaction_control.md
Name: transaction_control

Overview:
- Datapath-side sequencer for the ledger memory. It requests a load, captures the 48-bit ledger word and applies one transfer between accounts.
- It then hands the updated word back for write-back by raising process = 3'b100, and waits for the memory controller to return to idle.
- Ledger word layout: account 0 = bits [15:0], account 1 = [31:16], account 2 = [47:32], each unsigned 16-bit.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in any single handshake wait state before aborting.

Ports:
- clock  input  1  system clock
- resetn  input  1  synchronous, active-low reset
- start  input  1  one-cycle request to perform a transfer
- sender  input  2  source account index (0..2; 3 is invalid)
- receiver  input  2  destination account index (0..2; 3 is invalid)
- amount  input  16  unsigned transfer amount
- finished_init  input  1  memory initialisation complete
- mem_done  input  1  memory controller idle indication
- load_registers  input  1  memory read data valid
- mem_data  input  48  memory read data
- load_memory  output  1  load request to memory controller
- process  output  3  phase code to memory controller
- datapath_out  output  48  ledger word for write-back
- busy  output  1  transaction in progress
- tx_done  output  1  one-cycle completion pulse
- tx_ok  output  1  last transaction committed a change
- error_code  output  3  status of last transaction

Behaviour:
- Synchronous reset (resetn = 0 at clock edge) forces the state to IDLE and clears all outputs, ledger image and timeout counter: load_memory 0, process 000, datapath_out 0, busy 0, tx_done 0, tx_ok 0, error_code 000. Reset mid-transaction aborts immediately with no pulse.
- start, sender, receiver and amount are latched on the accepting edge. Later input changes are ignored until the next IDLE.
- States and process codes:
  - IDLE (000): accept start only when finished_init = 1 and mem_done = 1; otherwise start is dropped. On accept go to REQ_LOAD, busy = 1.
  - REQ_LOAD (001): load_memory = 1. When load_registers = 1, capture mem_data into the ledger image and go to COMPUTE. If load_registers and start arrive in the same cycle in IDLE, load_registers is ignored.
  - COMPUTE (011): exactly one cycle; checks are evaluated in this priority order:
    - sender or receiver = 3 -> error 001
    - sender = receiver -> error 010
    - balance[sender] < amount -> error 011
    - balance[receiver] + amount > 16'hFFFF (17-bit check) -> error 100
    - otherwise subtract from sender, add to receiver, error 000.
    - amount = 0 with valid distinct indices succeeds, image unchanged, tx_ok = 1.
    - Go to WB_WAIT.
  - WB_WAIT (100): process = 100 and datapath_out holds the image, either updated or unchanged on error. Write-back is always requested so the memory controller never stalls. Wait for mem_done = 0, set a seen-low flag, then go to WB_DONE.
  - WB_DONE (100): hold process = 100 until mem_done = 1. Then pulse tx_done for one cycle, set tx_ok = (error_code == 000), busy = 0, go to IDLE.
- datapath_out always reflects the internal ledger image. It is updated only on the COMPUTE edge and on capture, and holds its value in IDLE.
- Timeout: a counter clears on each state entry and increments in REQ_LOAD, WB_WAIT and WB_DONE. Reaching TIMEOUT_CYCLES:
  - sets error_code = 111, tx_ok = 0, and pulses tx_done;
  - returns to IDLE with the image unchanged and load_memory/process deasserted.
- error_code and tx_ok hold until the next accepted start, where both clear to 0.
- Transaction latency with an immediately responding memory: 1 (accept) + load wait + 1 (COMPUTE) + write-back wait + 1 (done pulse).

Test Plan:
- Reset, then finished_init = 1, mem_done = 1, start with sender 0, receiver 2, amount 100, mem_data = {16'd500, 16'd0, 16'd300}. Required: datapath_out = {16'd600, 16'd0, 16'd200}, process walks 001 -> 011 -> 100 -> 000, tx_done single pulse, tx_ok = 1, error_code 000.
- sender 1 with balance 50 and amount 51. Required: error_code 011, datapath_out equals captured word, process still reaches 100, tx_done pulses after mem_done low-then-high, tx_ok = 0.
- sender = receiver = 2: error 010. sender = 3: error 001. Receiver balance 16'hFFF0 with amount 16'h0020: error 100, image unchanged in each case.
- load_registers never asserted. Required: exactly 64 cycles after REQ_LOAD entry, error_code 111, tx_done pulse, load_memory = 0, busy = 0.
- start while finished_init = 0, and start while busy. Required: both ignored, no state change, no tx_done.
- resetn = 0 during WB_WAIT. Required: next cycle all outputs zero, no tx_done; a new transfer then completes normally.
